// File: rtl/sample_frame_buffer.sv
// Stereo sample FIFO that releases one pair per LRCLK frame to a serializer.
// Primes to a fill threshold before playback and falls back to priming on underrun.
module sample_frame_buffer #(
    parameter int NUM_OF_AMPLITUDE_BITS = 16,
    parameter int DIVISOR               = 512,
    parameter int FIFO_DEPTH            = 8,
    parameter int PRIME_LEVEL           = 4
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst_n,
    input  logic                             i_Sample_Valid,
    input  logic [NUM_OF_AMPLITUDE_BITS-1:0] i_Sample_Left,
    input  logic [NUM_OF_AMPLITUDE_BITS-1:0] i_Sample_Right,
    output logic                             o_Sample_Ready,
    output logic [NUM_OF_AMPLITUDE_BITS-1:0] o_Left,
    output logic [NUM_OF_AMPLITUDE_BITS-1:0] o_Right,
    output logic                             o_Frame_Strobe,
    output logic                             o_Underrun,
    output logic [$clog2(FIFO_DEPTH):0]      o_Fill_Level
);

    localparam int W    = NUM_OF_AMPLITUDE_BITS;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int LAST = DIVISOR - 1;

    localparam logic [CW-1:0] CNT_LAST = LAST[CW-1:0];
    localparam logic [AW:0]   DEPTH    = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   PRIME    = PRIME_LEVEL[AW:0];

    typedef enum logic {
        S_PRIME,
        S_PLAY
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       fill_q;
    logic [2*W-1:0]    mem [FIFO_DEPTH];
    logic [2*W-1:0]    rd_data;
    logic              tick;
    logic              push;
    logic              pop;
    logic              load;
    logic              underrun_d;

    assign tick    = (cnt_q == CNT_LAST);
    assign rd_data = mem[rd_ptr_q];

    // Ready is held low while reset is asserted, otherwise it tracks fill only.
    assign o_Sample_Ready = i_Rst_n && (fill_q < DEPTH);
    assign push           = i_Sample_Valid && o_Sample_Ready;
    assign o_Fill_Level   = fill_q;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        load       = 1'b0;
        underrun_d = 1'b0;
        if (tick) begin
            load = 1'b1;
            unique case (state_q)
                S_PRIME: begin
                    if (fill_q >= PRIME) state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (fill_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = S_PRIME;
                    end
                end
                default: state_d = S_PRIME;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q        <= S_PRIME;
            cnt_q          <= '0;
            o_Frame_Strobe <= 1'b0;
            o_Underrun     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= tick ? '0 : cnt_q + 1'b1;
            o_Frame_Strobe <= tick;
            o_Underrun     <= underrun_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (push) mem[wr_ptr_q] <= {i_Sample_Left, i_Sample_Right};
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Non-pop frame ticks (priming or underrun) play silence.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Left  <= '0;
            o_Right <= '0;
        end else if (load) begin
            o_Left  <= pop ? rd_data[2*W-1:W] : '0;
            o_Right <= pop ? rd_data[W-1:0]   : '0;
        end
    end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Directed bench for sample_frame_buffer at default parameters.
// Steps on falling edges; all expected values are hand-derived.
module tb_sample_frame_buffer;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n;
    logic        i_Sample_Valid;
    logic [15:0] i_Sample_Left;
    logic [15:0] i_Sample_Right;
    logic        o_Sample_Ready;
    logic [15:0] o_Left;
    logic [15:0] o_Right;
    logic        o_Frame_Strobe;
    logic        o_Underrun;
    logic [3:0]  o_Fill_Level;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int k      = 0;

    sample_frame_buffer dut (
        .i_Clk          (i_Clk),
        .i_Rst_n        (i_Rst_n),
        .i_Sample_Valid (i_Sample_Valid),
        .i_Sample_Left  (i_Sample_Left),
        .i_Sample_Right (i_Sample_Right),
        .o_Sample_Ready (o_Sample_Ready),
        .o_Left         (o_Left),
        .o_Right        (o_Right),
        .o_Frame_Strobe (o_Frame_Strobe),
        .o_Underrun     (o_Underrun),
        .o_Fill_Level   (o_Fill_Level)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock with current inputs; counting pattern advances on accept.
    task automatic step();
        logic acc;
        acc = i_Sample_Valid && o_Sample_Ready;
        @(negedge i_Clk);
        if (acc) begin
            n_acc++;
            k++;
            i_Sample_Left  = 16'h0100 + 16'(k);
            i_Sample_Right = 16'h0200 + 16'(k);
        end
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!o_Frame_Strobe && n < 600);
        if (!o_Frame_Strobe) check("strobe_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int viol;
        logic [15:0] pl;
        logic [15:0] pr;

        i_Rst_n        = 1'b0;
        i_Sample_Valid = 1'b0;
        i_Sample_Left  = '0;
        i_Sample_Right = '0;
        repeat (3) @(negedge i_Clk);
        check("rst_ready", o_Sample_Ready, 0);
        check("rst_fill", o_Fill_Level, 0);
        check("rst_left", o_Left, 0);
        check("rst_strobe", o_Frame_Strobe, 0);
        check("rst_underrun", o_Underrun, 0);
        i_Rst_n = 1'b1;
        #1;
        check("rel_ready", o_Sample_Ready, 1);

        // Four pairs, then idle: prime frame, four data frames, underrun.
        for (int i = 0; i < 4; i++) begin
            i_Sample_Valid = 1'b1;
            i_Sample_Left  = 16'h1111 * 16'(i + 1);
            i_Sample_Right = 16'h1111 * 16'(i + 2);
            step();
        end
        i_Sample_Valid = 1'b0;
        check("fill4", o_Fill_Level, 4);
        wait_strobe();
        check("f1_left", o_Left, 0);
        check("f1_right", o_Right, 0);
        check("f1_fill", o_Fill_Level, 4);
        for (int i = 0; i < 4; i++) begin
            wait_strobe();
            check("fN_left", o_Left, 16'h1111 * 16'(i + 1));
            check("fN_right", o_Right, 16'h1111 * 16'(i + 2));
            check("fN_fill", o_Fill_Level, 32'(3 - i));
            check("fN_nounder", o_Underrun, 0);
        end
        wait_strobe();
        check("f6_left", o_Left, 0);
        check("f6_right", o_Right, 0);
        check("f6_underrun", o_Underrun, 1);
        step();
        check("underrun_pulse", o_Underrun, 0);

        // Continuous valid with counting pattern: saturate at eight.
        k              = 0;
        n_acc          = 0;
        i_Sample_Left  = 16'h0100;
        i_Sample_Right = 16'h0200;
        i_Sample_Valid = 1'b1;
        repeat (20) step();
        check("sat_acc", n_acc, 8);
        check("sat_fill", o_Fill_Level, 8);
        check("sat_ready", o_Sample_Ready, 0);
        wait_strobe();
        check("prime_left", o_Left, 0);
        check("prime_fill", o_Fill_Level, 8);
        wait_strobe();
        check("full_pop_left", o_Left, 16'h0100);
        check("full_pop_right", o_Right, 16'h0200);
        check("full_pop_fill", o_Fill_Level, 7);
        check("full_pop_ready", o_Sample_Ready, 1);
        check("full_no_push", n_acc, 8);
        step();
        check("refill_acc", n_acc, 9);
        check("refill_fill", o_Fill_Level, 8);
        check("refill_ready", o_Sample_Ready, 0);
        i_Sample_Valid = 1'b0;

        // Drain to three, then push on the tick edge.
        for (int i = 1; i <= 5; i++) begin
            wait_strobe();
            check("drain_left", o_Left, 16'h0100 + 16'(i));
            check("drain_fill", o_Fill_Level, 32'(8 - i));
        end
        repeat (511) step();
        i_Sample_Valid = 1'b1;
        i_Sample_Left  = 16'hAAAA;
        i_Sample_Right = 16'h5555;
        step();
        i_Sample_Valid = 1'b0;
        check("same_edge_strobe", o_Frame_Strobe, 1);
        check("same_edge_left", o_Left, 16'h0106);
        check("same_edge_fill", o_Fill_Level, 3);

        // Mid-frame reset at counter 200 with five entries.
        i_Sample_Valid = 1'b1;
        i_Sample_Left  = 16'h1234;
        i_Sample_Right = 16'h4321;
        repeat (2) step();
        i_Sample_Valid = 1'b0;
        repeat (198) step();
        check("pre_rst_fill", o_Fill_Level, 5);
        i_Rst_n = 1'b0;
        #1;
        check("mid_rst_left", o_Left, 0);
        check("mid_rst_right", o_Right, 0);
        check("mid_rst_fill", o_Fill_Level, 0);
        check("mid_rst_ready", o_Sample_Ready, 0);
        check("mid_rst_strobe", o_Frame_Strobe, 0);
        check("mid_rst_underrun", o_Underrun, 0);
        repeat (3) step();
        i_Rst_n = 1'b1;
        #1;
        check("rel2_ready", o_Sample_Ready, 1);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_Frame_Strobe && n < 600);
        check("rel2_first_strobe", n, 512);
        check("rel2_fill", o_Fill_Level, 0);
        check("rel2_left", o_Left, 0);

        // Random traffic: strobe period and output stability.
        viol = 0;
        for (int f = 0; f < 20; f++) begin
            n  = 0;
            pl = o_Left;
            pr = o_Right;
            do begin
                i_Sample_Valid = ($urandom_range(0, 31) == 0);
                i_Sample_Left  = 16'($urandom);
                i_Sample_Right = 16'($urandom);
                step();
                n++;
                if (!o_Frame_Strobe && (o_Left !== pl || o_Right !== pr))
                    viol++;
            end while (!o_Frame_Strobe && n < 600);
            check("rand_period", n, 512);
        end
        i_Sample_Valid = 1'b0;
        check("rand_stable", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
